// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage MIPS pipeline, with E/M/W hazard shadow and MDU interlock.
// Define HAZ_FWD_EN for TUse/TNew stalling with forwarding; otherwise a stall-only interlock is built.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] D_tuse_rs,
    input  logic [2:0] D_tuse_rt,
    input  logic [2:0] D_tnew,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [4:0] D_dst,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_md_use,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       md_busy
);

    localparam logic [2:0]       TUSE_NONE = 3'b101;
    localparam logic [CNT_W-1:0] MULT_LD   = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD    = CNT_W'(DIV_CYC);

    logic [4:0]       r_E_dst;
    logic [4:0]       r_M_dst;
    logic             r_E_md_start;
    logic             r_E_md_div;
    logic [CNT_W-1:0] r_busy_cnt;

    logic w_stall;
    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_md;

    // $0 is hard-wired, so it never participates in a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_E_dst      <= '0;
            r_M_dst      <= '0;
            r_E_md_start <= 1'b0;
            r_E_md_div   <= 1'b0;
        end else begin
            if (w_stall) begin
                r_E_dst      <= '0;
                r_E_md_start <= 1'b0;
                r_E_md_div   <= 1'b0;
            end else begin
                r_E_dst      <= D_dst;
                r_E_md_start <= D_md_start;
                r_E_md_div   <= D_md_div;
            end
            r_M_dst <= r_E_dst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_cnt <= '0;
        end else if (r_E_md_start) begin
            r_busy_cnt <= r_E_md_div ? DIV_LD : MULT_LD;
        end else if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        w_stall_md = D_md_use && ((r_busy_cnt != '0) || r_E_md_start);
    end

`ifdef HAZ_FWD_EN
    logic [2:0] r_E_tnew;
    logic [2:0] r_M_tnew;
    logic [4:0] r_E_rs;
    logic [4:0] r_E_rt;
    logic [4:0] r_W_dst;

    function automatic logic [2:0] sat0_dec(input logic [2:0] x);
        return (x == 3'd0) ? 3'd0 : x - 3'd1;
    endfunction

    function automatic logic stall_term(input logic [4:0] src, input logic [2:0] tuse,
                                        input logic [4:0] e_dst, input logic [2:0] e_tnew,
                                        input logic [4:0] m_dst, input logic [2:0] m_tnew);
        // An unused operand (TUse 5) exceeds any reachable TNew, so it never stalls.
        return (reg_match(src, e_dst) && (tuse < e_tnew)) ||
               (reg_match(src, m_dst) && (tuse < m_tnew));
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [4:0] src,
                                             input logic [4:0] e_dst, input logic [2:0] e_tnew,
                                             input logic [4:0] m_dst, input logic [2:0] m_tnew,
                                             input logic [4:0] w_dst);
        if (reg_match(src, e_dst) && (e_tnew == 3'd0)) return 2'd3;
        if (reg_match(src, m_dst) && (m_tnew == 3'd0)) return 2'd2;
        if (reg_match(src, w_dst))                     return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] src,
                                             input logic [4:0] m_dst, input logic [2:0] m_tnew,
                                             input logic [4:0] w_dst);
        if (reg_match(src, m_dst) && (m_tnew == 3'd0)) return 2'd2;
        if (reg_match(src, w_dst))                     return 2'd1;
        return 2'd0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_E_tnew <= '0;
            r_M_tnew <= '0;
            r_E_rs   <= '0;
            r_E_rt   <= '0;
            r_W_dst  <= '0;
        end else begin
            if (w_stall) begin
                r_E_tnew <= '0;
                r_E_rs   <= '0;
                r_E_rt   <= '0;
            end else begin
                r_E_tnew <= sat0_dec(D_tnew);
                r_E_rs   <= D_rs;
                r_E_rt   <= D_rt;
            end
            r_M_tnew <= sat0_dec(r_E_tnew);
            r_W_dst  <= r_M_dst;
        end
    end

    always_comb begin
        w_stall_rs = stall_term(D_rs, D_tuse_rs, r_E_dst, r_E_tnew, r_M_dst, r_M_tnew);
        w_stall_rt = stall_term(D_rt, D_tuse_rt, r_E_dst, r_E_tnew, r_M_dst, r_M_tnew);
        fwd_rs_D   = fwd_d_sel(D_rs, r_E_dst, r_E_tnew, r_M_dst, r_M_tnew, r_W_dst);
        fwd_rt_D   = fwd_d_sel(D_rt, r_E_dst, r_E_tnew, r_M_dst, r_M_tnew, r_W_dst);
        fwd_rs_E   = fwd_e_sel(r_E_rs, r_M_dst, r_M_tnew, r_W_dst);
        fwd_rt_E   = fwd_e_sel(r_E_rt, r_M_dst, r_M_tnew, r_W_dst);
    end
`else
    logic r_E_vld;
    logic r_M_vld;

    function automatic logic stall_term(input logic [4:0] src, input logic [2:0] tuse,
                                        input logic [4:0] e_dst, input logic e_vld,
                                        input logic [4:0] m_dst, input logic m_vld);
        return (tuse != TUSE_NONE) &&
               ((reg_match(src, e_dst) && e_vld) || (reg_match(src, m_dst) && m_vld));
    endfunction

    // Without forwarding, any in-flight writer blocks readers until it reaches W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_E_vld <= 1'b0;
            r_M_vld <= 1'b0;
        end else begin
            r_E_vld <= w_stall ? 1'b0 : (D_tnew != 3'd0);
            r_M_vld <= r_E_vld;
        end
    end

    always_comb begin
        w_stall_rs = stall_term(D_rs, D_tuse_rs, r_E_dst, r_E_vld, r_M_dst, r_M_vld);
        w_stall_rt = stall_term(D_rt, D_tuse_rt, r_E_dst, r_E_vld, r_M_dst, r_M_vld);
        fwd_rs_D   = 2'd0;
        fwd_rt_D   = 2'd0;
        fwd_rs_E   = 2'd0;
        fwd_rt_E   = 2'd0;
    end
`endif

    always_comb begin
        w_stall = w_stall_rs || w_stall_rt || w_stall_md;
        stall   = w_stall;
        md_busy = (r_busy_cnt != '0);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table plus MDU and async-reset sequences.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] d_tuse_rs;
    logic [2:0] d_tuse_rt;
    logic [2:0] d_tnew;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [4:0] d_dst;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       stall;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic [1:0] fwd_rs_E;
    logic [1:0] fwd_rt_E;
    logic       md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_tuse_rs  (d_tuse_rs),
        .D_tuse_rt  (d_tuse_rt),
        .D_tnew     (d_tnew),
        .D_rs       (d_rs),
        .D_rt       (d_rt),
        .D_dst      (d_dst),
        .D_md_start (d_md_start),
        .D_md_div   (d_md_div),
        .D_md_use   (d_md_use),
        .stall      (stall),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] tuse_rs;
        logic [2:0] tuse_rt;
        logic [2:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       stall_n;   // expected stall, stall-only build
        logic       stall_f;   // expected stall, forwarding build
        logic [1:0] frsd;
        logic [1:0] frtd;
        logic [1:0] frse;
        logic [1:0] frte;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    function automatic vec_t mk(input int tur, input int tut, input int tn, input int rs,
                                input int rt, input int dst, input int sn, input int sf,
                                input int a, input int b, input int c, input int d);
        vec_t v;
        v.tuse_rs = 3'(tur); v.tuse_rt = 3'(tut); v.tnew = 3'(tn);
        v.rs = 5'(rs); v.rt = 5'(rt); v.dst = 5'(dst);
        v.stall_n = 1'(sn); v.stall_f = 1'(sf);
        v.frsd = 2'(a); v.frtd = 2'(b); v.frse = 2'(c); v.frte = 2'(d);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int tur, input int tut, input int tn, input int rs, input int rt,
                         input int dst, input int mds, input int mdd, input int mdu);
        d_tuse_rs = 3'(tur); d_tuse_rt = 3'(tut); d_tnew = 3'(tn);
        d_rs = 5'(rs); d_rt = 5'(rt); d_dst = 5'(dst);
        d_md_start = 1'(mds); d_md_div = 1'(mdd); d_md_use = 1'(mdu);
    endtask

    // Drive on the falling edge, sample 3 ns later, well before the next rising edge.
    task automatic step(input int tur, input int tut, input int tn, input int rs, input int rt,
                        input int dst, input int mds, input int mdd, input int mdu);
        @(negedge clk);
        drive(tur, tut, tn, rs, rt, dst, mds, mdd, mdu);
        #3;
    endtask

    task automatic chk_fwd_zero(input string tag);
        chk({tag, "_fwd_rs_D"}, int'(fwd_rs_D), 0);
        chk({tag, "_fwd_rt_D"}, int'(fwd_rt_D), 0);
        chk({tag, "_fwd_rs_E"}, int'(fwd_rs_E), 0);
        chk({tag, "_fwd_rt_E"}, int'(fwd_rt_E), 0);
    endtask

    initial begin
        //              tur tut tn rs  rt dst sn sf rsD rtD rsE rtE
        tbl[0] = mk(1, 5, 3, 29, 0, 8,  0, 0, 0, 0, 0, 0);  // lw $8
        tbl[1] = mk(1, 1, 2, 8,  9, 10, 1, 1, 0, 0, 0, 0);  // addu $10,$8,$9 vs lw in E
        tbl[2] = mk(1, 1, 2, 8,  9, 10, 1, 0, 0, 0, 0, 0);  // lw now in M (tnew 1)
        tbl[3] = mk(0, 0, 0, 10, 8, 0,  0, 1, 0, 1, 1, 0);  // beq $10,$8 vs addu in E
        tbl[4] = mk(0, 0, 0, 10, 8, 0,  0, 0, 2, 0, 0, 0);  // addu in M, tnew 0
        tbl[5] = mk(1, 5, 2, 3,  0, 0,  0, 0, 0, 0, 1, 0);  // ori $0,$3
        tbl[6] = mk(1, 1, 2, 0,  0, 5,  0, 0, 0, 0, 0, 0);  // addu $5,$0,$0 after ori $0
        tbl[7] = mk(5, 5, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);  // nop
        tbl[8] = mk(1, 2, 0, 29, 5, 0,  1, 0, 0, 2, 0, 0);  // sw $5 with addu $5 in M
        tbl[9] = mk(5, 5, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1);  // nop, sw in E

        reset = 1'b1;
        drive(1, 1, 2, 8, 9, 10, 0, 0, 1);
        #3;
        chk("rst_stall", int'(stall), 0);
        chk("rst_md_busy", int'(md_busy), 0);
        chk_fwd_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].tuse_rs, tbl[i].tuse_rt, tbl[i].tnew, tbl[i].rs, tbl[i].rt,
                 tbl[i].dst, 0, 0, 0);
`ifdef HAZ_FWD_EN
            chk($sformatf("v%0d_stall", i), int'(stall), int'(tbl[i].stall_f));
            chk($sformatf("v%0d_fwd_rs_D", i), int'(fwd_rs_D), int'(tbl[i].frsd));
            chk($sformatf("v%0d_fwd_rt_D", i), int'(fwd_rt_D), int'(tbl[i].frtd));
            chk($sformatf("v%0d_fwd_rs_E", i), int'(fwd_rs_E), int'(tbl[i].frse));
            chk($sformatf("v%0d_fwd_rt_E", i), int'(fwd_rt_E), int'(tbl[i].frte));
`else
            chk($sformatf("v%0d_stall", i), int'(stall), int'(tbl[i].stall_n));
            chk_fwd_zero($sformatf("v%0d", i));
`endif
            chk($sformatf("v%0d_md_busy", i), int'(md_busy), 0);
        end

        // mult followed by non-HI/LO instructions: busy 5 cycles, no stall
        step(1, 1, 0, 0, 0, 0, 1, 0, 1);
        chk("mult_issue_stall", int'(stall), 0);
        for (int k = 1; k <= 7; k++) begin
            step(5, 5, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("mult_k%0d_busy", k), int'(md_busy), (k >= 2 && k <= 6) ? 1 : 0);
            chk($sformatf("mult_k%0d_stall", k), int'(stall), 0);
        end

        // div then mflo: stall in div's E cycle plus 10 busy cycles
        begin
            int busy_cycles;
            busy_cycles = 0;
            step(1, 1, 0, 0, 0, 0, 1, 1, 1);
            chk("div_issue_stall", int'(stall), 0);
            for (int k = 1; k <= 12; k++) begin
                step(5, 5, 2, 0, 0, 0, 0, 0, 1);
                chk($sformatf("div_k%0d_stall", k), int'(stall), (k <= 11) ? 1 : 0);
                chk($sformatf("div_k%0d_busy", k), int'(md_busy), (k >= 2 && k <= 11) ? 1 : 0);
                if (md_busy) busy_cycles++;
            end
            chk("div_busy_cycles", busy_cycles, 10);
        end

        // Async reset while busy_cnt=6 and mflo stalled
        step(1, 1, 0, 0, 0, 0, 1, 1, 1);
        for (int k = 1; k <= 6; k++) step(5, 5, 2, 0, 0, 0, 0, 0, 1);
        chk("pre_rst_stall", int'(stall), 1);
        chk("pre_rst_busy", int'(md_busy), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_stall", int'(stall), 0);
        chk("async_rst_busy", int'(md_busy), 0);
        chk_fwd_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(5, 5, 2, 0, 0, 0, 0, 0, 1);
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_busy", int'(md_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
